vga_blit: RTL
=============

Name: vga_blit

Overview:
Wishbone rectangle-fill engine that sits directly upstream of the VGA frame-buffer peripheral. Software programs a rectangle (X, Y, W, H) and an 8-bit palette index through a Wishbone slave register port. The block then streams single-byte writes into VRAM through its Wishbone master port, one transaction per pixel, so the CPU is not tied up in pixel loops. The frame buffer is linear, row-major, H_RES pixels per row, byte address = y*H_RES + x.

Parameters:
H_RES, 640, pixels per row; also the row stride.
V_RES, 480, number of rows.
ADDR_W, 19, width of the master address bus (VRAM byte space).

Ports:
wb_clk_i  in  1  system clock; every flop is on the rising edge.
wb_rst_i  in  1  reset; asynchronous assert, active-low; release is synchronous to wb_clk_i externally.
wb_cyc_i  in  1  slave cycle.
wb_stb_i  in  1  slave strobe.
wb_adr_i  in  32  slave address; bits [4:2] select the register.
wb_we_i  in  1  slave write enable.
wb_sel_i  in  4  byte selects; ignored, full-word access.
wb_dat_i  in  32  slave write data.
wb_dat_o  out  32  slave read data.
wb_ack_o  out  1  slave acknowledge.
wbm_cyc_o  out  1  master cycle.
wbm_stb_o  out  1  master strobe.
wbm_we_o  out  1  master write enable; 1 whenever wbm_stb_o is 1.
wbm_adr_o  out  ADDR_W  master pixel byte address.
wbm_dat_o  out  32  master data: {24'b0, COLOR}.
wbm_ack_i  in  1  master acknowledge from the VGA peripheral.
irq_o  out  1  fill-complete interrupt (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0.
  - X0, Y0, W, H, COLOR = 0; busy = 0, done = 0; FSM in IDLE.
- Slave ack:
  - Registered: ack <= cs & !ack, where cs = wb_cyc_i & wb_stb_i.
  - Register writes commit on the cycle cs & wb_we_i & !ack.
  - Read data is registered and valid with ack.
- Register map, by wb_adr_i[4:2]:
  - 0: X0[9:0]
  - 1: Y0[9:0]
  - 2: W[10:0]
  - 3: H[9:0]
  - 4: COLOR[7:0]
  - 5: CTRL.
  - Unused bits read 0. Unmapped offsets read 0 and ignore writes.
- CTRL bits:
  - bit0 START: write-1 pulse, reads 0.
  - bit1 BUSY: read-only.
  - bit2 DONE: sticky, write-1-to-clear.
  - bit3 IRQ_EN: read/write.
- START:
  - Accepted only in IDLE; ignored while BUSY.
  - A write that carries both START and DONE-clear clears DONE first, then starts.
  - Register writes during BUSY are stored but affect only the next START.
- FSM:
  - IDLE --START--> SETUP.
  - SETUP:
    - Latch COLOR.
    - Clip the rectangle: x_end = min(X0+W, H_RES), y_end = min(Y0+H, V_RES).
    - Load row_base = Y0*H_RES, computed once at start, not per pixel.
    - If W==0, H==0, X0>=H_RES or Y0>=V_RES, go to DONE with no bus activity; otherwise go to WRITE with x=X0, y=Y0.
  - WRITE:
    - Drive wbm_cyc_o = wbm_stb_o = wbm_we_o = 1 and wbm_adr_o = row_base + x.
    - Hold all of them until wbm_ack_i is sampled 1, then go to GAP.
  - GAP:
    - cyc/stb = 0 for exactly one cycle; the downstream ack is level-held while its strobe is high.
    - Advance x.
    - If x+1 == x_end: reset x to X0, increment y, row_base += H_RES.
    - If y+1 == y_end, go to DONE; otherwise go to WRITE.
  - DONE: set the DONE bit, clear BUSY, go to IDLE; takes 1 cycle.
- BUSY is 1 from the cycle after START is accepted through the DONE state.
- Throughput with the 1-cycle-ack peripheral: 3 cycles per pixel, plus SETUP and DONE.
- Pixel order: row-major, ascending x, then ascending y. No pixel is written twice.
- Reset mid-fill: cyc/stb drop immediately (asynchronous), the fill is abandoned, and the slave registers return to their reset values.

Optional Feature:
Macro VGA_BLIT_IRQ_EN.
- Defined:
  - irq_o = DONE & IRQ_EN, level output, registered.
  - irq_o clears when software writes 1 to CTRL[2].
- Undefined:
  - irq_o is tied to 0.
  - CTRL[3] reads 0 and ignores writes.
  - No interrupt logic is synthesised.

Test Plan:
1. X0=0, Y0=0, W=1, H=1, COLOR=0x5A, START -> exactly one master write: adr 0, dat 0x0000005A. DONE=1, BUSY=0 after the DONE state.
2. X0=10, Y0=5, W=3, H=2, COLOR=0x11 -> six writes, in this order: adr 3210, 3211, 3212, 3850, 3851, 3852. cyc/stb low for exactly 1 cycle between writes.
3. Clip case X0=638, Y0=479, W=4, H=4 -> exactly two writes, adr 307198 then 307199; DONE set.
4. W=0, START -> no wbm_cyc_o assertion at all; DONE=1 within 3 cycles of the START ack.
5. A 100x1 fill with START rewritten at pixel 40 -> the second START is ignored and exactly 100 writes are issued. Then assert wb_rst_i low mid-way through a second fill -> wbm_cyc_o goes to 0 in the same cycle and all registers read 0 after release.
6. VGA_BLIT_IRQ_EN defined, IRQ_EN=1 -> irq_o rises the cycle after DONE sets; writing CTRL=0x4 clears irq_o. With the macro undefined, irq_o stays 0 for the whole test.

Source files
------------

// File: rtl/vga_blit.sv
// vga_blit: Wishbone rectangle fill into linear VRAM; optional irq under VGA_BLIT_IRQ_EN.
// Latency: SETUP + 3 cycles/pixel with a 1-cycle-ack target + DONE; slave ack is 1 registered cycle.
// Backpressure: each pixel write holds cyc/stb/adr until wbm_ack_i, then drops strobe for one cycle.
module vga_blit #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [31:0]       wb_adr_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic              wbm_ack_i,
    output logic              irq_o
);

    localparam logic [11:0] H_RES_W = 12'(H_RES);
    localparam logic [11:0] V_RES_W = 12'(V_RES);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_GAP, S_DONE} state_t;

    state_t state, state_n;

    logic [9:0]  x0_r, y0_r, h_r;
    logic [10:0] w_r;
    logic [7:0]  color_r;
    logic        done_r;
    logic        irq_en;
    logic        ack_r;
    logic [31:0] rd_val;

    logic [9:0]        x0_q, x_q, y_q, x_end_q, y_end_q;
    logic [7:0]        color_q;
    logic [ADDR_W-1:0] row_base;

    logic        cs, wr, ctrl_wr, start_acc, busy;
    logic [2:0]  reg_sel;
    logic [11:0] sum_x, sum_y;
    logic [9:0]  x_end_c, y_end_c;
    logic        empty, x_last, y_last;

    assign cs        = wb_cyc_i & wb_stb_i;
    assign wr        = cs & wb_we_i & ~ack_r;
    assign reg_sel   = wb_adr_i[4:2];
    assign ctrl_wr   = wr & (reg_sel == 3'd5);
    assign start_acc = ctrl_wr & wb_dat_i[0] & (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:11]};

    // Clip against the screen edges from the live registers; only sampled in SETUP.
    assign sum_x   = {2'b00, x0_r} + {1'b0, w_r};
    assign sum_y   = {2'b00, y0_r} + {2'b00, h_r};
    assign x_end_c = (sum_x > H_RES_W) ? H_RES_W[9:0] : sum_x[9:0];
    assign y_end_c = (sum_y > V_RES_W) ? V_RES_W[9:0] : sum_y[9:0];
    assign empty   = (w_r == 11'd0) || (h_r == 10'd0) ||
                     ({2'b00, x0_r} >= H_RES_W) || ({2'b00, y0_r} >= V_RES_W);

    assign x_last = ({1'b0, x_q} + 11'd1) == {1'b0, x_end_q};
    assign y_last = ({1'b0, y_q} + 11'd1) == {1'b0, y_end_q};

    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            3'd0:    rd_val = {22'd0, x0_r};
            3'd1:    rd_val = {22'd0, y0_r};
            3'd2:    rd_val = {21'd0, w_r};
            3'd3:    rd_val = {22'd0, h_r};
            3'd4:    rd_val = {24'd0, color_r};
            3'd5:    rd_val = {28'd0, irq_en, done_r, busy, 1'b0};
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_r    <= 1'b0;
            wb_dat_o <= 32'd0;
            x0_r     <= 10'd0;
            y0_r     <= 10'd0;
            w_r      <= 11'd0;
            h_r      <= 10'd0;
            color_r  <= 8'd0;
        end else begin
            ack_r    <= cs & ~ack_r;
            wb_dat_o <= (cs & ~ack_r) ? rd_val : 32'd0;
            if (wr) begin
                case (reg_sel)
                    3'd0:    x0_r    <= wb_dat_i[9:0];
                    3'd1:    y0_r    <= wb_dat_i[9:0];
                    3'd2:    w_r     <= wb_dat_i[10:0];
                    3'd3:    h_r     <= wb_dat_i[9:0];
                    3'd4:    color_r <= wb_dat_i[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign wb_ack_o = ack_r;

    // A completing fill wins over a simultaneous clear so a finish is never lost.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            done_r <= 1'b0;
        end else if (state == S_DONE) begin
            done_r <= 1'b1;
        end else if (ctrl_wr & wb_dat_i[2]) begin
            done_r <= 1'b0;
        end
    end

`ifdef VGA_BLIT_IRQ_EN
    logic irq_r;
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            irq_en <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= wb_dat_i[3];
            irq_r <= done_r & irq_en;
        end
    end
    assign irq_o = irq_r;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state <= S_IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_acc) state_n = S_SETUP;
            S_SETUP: state_n = empty ? S_DONE : S_WRITE;
            S_WRITE: if (wbm_ack_i) state_n = S_GAP;
            S_GAP:   state_n = (x_last && y_last) ? S_DONE : S_WRITE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Fill context is snapshotted in SETUP so register writes during a fill only affect the next one.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            x0_q     <= 10'd0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            x_end_q  <= 10'd0;
            y_end_q  <= 10'd0;
            color_q  <= 8'd0;
            row_base <= '0;
        end else if (state == S_SETUP) begin
            x0_q     <= x0_r;
            x_q      <= x0_r;
            y_q      <= y0_r;
            x_end_q  <= x_end_c;
            y_end_q  <= y_end_c;
            color_q  <= color_r;
            row_base <= ADDR_W'(32'(y0_r) * 32'(H_RES));
        end else if (state == S_GAP) begin
            if (x_last) begin
                x_q      <= x0_q;
                y_q      <= y_q + 10'd1;
                row_base <= row_base + ADDR_W'(H_RES);
            end else begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    assign wbm_cyc_o = (state == S_WRITE);
    assign wbm_stb_o = (state == S_WRITE);
    assign wbm_we_o  = (state == S_WRITE);
    assign wbm_adr_o = row_base + ADDR_W'(x_q);
    assign wbm_dat_o = {24'd0, color_q};

endmodule
